// File: rtl/cnn_argmax_readout.sv
// rtl/cnn_argmax_readout.sv - argmax readout of NCLASS signed class scores from the data BRAM (optional ARGMAX_TOP2_EN adds runner-up/margin)
module cnn_argmax_readout #(
    parameter int WIDTH      = 16,
    parameter int DECIMAL    = 8,
    parameter int MEMADDRBIT = 20,
    parameter int NCLASS     = 10,
    parameter int RDLAT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MEMADDRBIT-1:0] base_addr,
    output logic [MEMADDRBIT-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [WIDTH-1:0]      mem_out,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            class_idx,
    output logic [WIDTH-1:0]      class_score
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [7:0]            second_idx,
    output logic [WIDTH:0]        margin
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [7:0] LAST_IDX  = 8'(NCLASS - 1);
    localparam logic [1:0] LAST_WAIT = 2'(RDLAT - 1);

    generate
        if (DECIMAL >= WIDTH || NCLASS < 1 || NCLASS > 255 || RDLAT < 1 || RDLAT > 3) begin : g_param_check
            $error("cnn_argmax_readout: parameter out of range");
        end
    endgenerate

    state_t               state;
    logic [7:0]           cnt;
    logic [1:0]           dcnt;
    logic [RDLAT-1:0]     tag_vld;
    logic [7:0]           tag_idx [RDLAT];
    logic [WIDTH-1:0]     best, best_nxt;
    logic [7:0]           best_idx, best_idx_nxt;
    logic                 ret_vld;
    logic [7:0]           ret_idx;

    assign ret_vld = tag_vld[RDLAT-1];
    assign ret_idx = tag_idx[RDLAT-1];

`ifdef ARGMAX_TOP2_EN
    logic [WIDTH-1:0]     sec, sec_nxt;
    logic [7:0]           sec_idx, sec_idx_nxt;
    logic                 sec_vld, sec_vld_nxt;
    logic [WIDTH:0]       diff;

    // best >= second always holds, so the sign-extended difference is a valid unsigned value
    assign diff = {best_nxt[WIDTH-1], best_nxt} - {sec_nxt[WIDTH-1], sec_nxt};
`endif

    // mem_out is only looked at when a tagged read returns, so X elsewhere cannot leak in
    always_comb begin
        best_nxt     = best;
        best_idx_nxt = best_idx;
`ifdef ARGMAX_TOP2_EN
        sec_nxt      = sec;
        sec_idx_nxt  = sec_idx;
        sec_vld_nxt  = sec_vld;
`endif
        if (ret_vld) begin
            if (ret_idx == 8'd0) begin
                best_nxt     = mem_out;
                best_idx_nxt = ret_idx;
`ifdef ARGMAX_TOP2_EN
                sec_nxt      = '0;
                sec_idx_nxt  = 8'd0;
                sec_vld_nxt  = 1'b0;
`endif
            end else if ($signed(mem_out) > $signed(best)) begin
`ifdef ARGMAX_TOP2_EN
                sec_nxt      = best;
                sec_idx_nxt  = best_idx;
                sec_vld_nxt  = 1'b1;
`endif
                best_nxt     = mem_out;
                best_idx_nxt = ret_idx;
            end
`ifdef ARGMAX_TOP2_EN
            else if (!sec_vld || $signed(mem_out) > $signed(sec)) begin
                sec_nxt      = mem_out;
                sec_idx_nxt  = ret_idx;
                sec_vld_nxt  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            dcnt        <= 2'd0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            class_idx   <= 8'd0;
            class_score <= '0;
            best        <= '0;
            best_idx    <= 8'd0;
            tag_vld     <= '0;
            for (int j = 0; j < RDLAT; j++) tag_idx[j] <= 8'd0;
`ifdef ARGMAX_TOP2_EN
            sec         <= '0;
            sec_idx     <= 8'd0;
            sec_vld     <= 1'b0;
            second_idx  <= 8'd0;
            margin      <= '0;
`endif
        end else begin
            tag_vld[0] <= mem_rd_en;
            tag_idx[0] <= cnt;
            for (int j = 1; j < RDLAT; j++) begin
                tag_vld[j] <= tag_vld[j-1];
                tag_idx[j] <= tag_idx[j-1];
            end
            best     <= best_nxt;
            best_idx <= best_idx_nxt;
`ifdef ARGMAX_TOP2_EN
            sec      <= sec_nxt;
            sec_idx  <= sec_idx_nxt;
            sec_vld  <= sec_vld_nxt;
`endif
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state     <= S_ISSUE;
                    mem_addr  <= base_addr;
                    mem_rd_en <= 1'b1;
                    cnt       <= 8'd0;
                    busy      <= 1'b1;
                end
                S_ISSUE: if (cnt == LAST_IDX) begin
                    mem_rd_en <= 1'b0;
                    dcnt      <= 2'd0;
                    state     <= S_DRAIN;
                end else begin
                    cnt      <= cnt + 8'd1;
                    mem_addr <= mem_addr + MEMADDRBIT'(1);
                end
                // the final word is sampled on this same edge, hence the *_nxt values
                S_DRAIN: if (dcnt == LAST_WAIT) begin
                    state       <= S_DONE;
                    done        <= 1'b1;
                    class_idx   <= best_idx_nxt;
                    class_score <= best_nxt;
`ifdef ARGMAX_TOP2_EN
                    second_idx  <= sec_vld_nxt ? sec_idx_nxt : 8'd0;
                    margin      <= sec_vld_nxt ? diff : '0;
`endif
                end else begin
                    dcnt <= dcnt + 2'd1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
